// File: rtl/rand_category_picker.sv
// rtl/rand_category_picker.sv - weighted random category picker over an LFSR, valid/ready request/response
// Optional RAND_PICK_NO_REPEAT_EN: the last issued category is excluded from the next draw when possible.
module rand_category_picker #(
  parameter int                NUM_CAT    = 8,
  parameter int                WEIGHT_W   = 4,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
  parameter int                MAX_REJECT = 4,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [NUM_CAT-1:0]          req_mask,
  input  logic [NUM_CAT*WEIGHT_W-1:0] req_weights,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [NUM_CAT-1:0]          rsp_onehot,
  output logic [$clog2(NUM_CAT)-1:0]  rsp_index,
  output logic                        rsp_err,
  input  logic                        seed_load,
  input  logic [LFSR_W-1:0]           seed_val
);

  localparam int IDX_W = $clog2(NUM_CAT);
  localparam int SUM_W = WEIGHT_W + IDX_W;
  localparam int REJ_W = $clog2(MAX_REJECT + 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    SCAN,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d, lfsr_step;
  logic [WEIGHT_W-1:0] w_q [NUM_CAT];
  logic [WEIGHT_W-1:0] w_d [NUM_CAT];
  logic [WEIGHT_W-1:0] w_in [NUM_CAT];
  logic [SUM_W-1:0]    total_q, total_d, t_in;
  logic [SUM_W-1:0]    r_q, r_d;
  logic [SUM_W-1:0]    acc_q, acc_d, acc_next;
  logic [SUM_W-1:0]    draw_raw, draw, range_mask;
  logic [REJ_W-1:0]    rej_q, rej_d;
  logic [IDX_W-1:0]    scan_q, scan_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [NUM_CAT-1:0]  onehot_q, onehot_d;
  logic                err_q, err_d;

`ifdef RAND_PICK_NO_REPEAT_EN
  logic                last_vld_q, last_vld_d;
  logic [IDX_W-1:0]    last_idx_q, last_idx_d;
`endif

  always_comb begin
    lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    if (seed_load) begin
      lfsr_d = (seed_val == '0) ? SEED : seed_val;
    end else begin
      lfsr_d = lfsr_step;
    end
  end

  // Low bits XOR bit-reversed high bits: consecutive Galois states are near-shifts of
  // each other, so raw low bits would make a rejected draw bias the retry toward high r.
  always_comb begin
    range_mask = total_q;
    for (int s = 1; s < SUM_W; s++) begin
      range_mask = range_mask | (range_mask >> 1);
    end
    for (int k = 0; k < SUM_W; k++) begin
      draw_raw[k] = lfsr_q[k] ^ lfsr_q[LFSR_W-1-k];
    end
    draw = draw_raw & range_mask;
  end

  always_comb begin
    t_in = '0;
    for (int i = 0; i < NUM_CAT; i++) begin
      w_in[i] = req_mask[i] ? req_weights[i*WEIGHT_W +: WEIGHT_W] : '0;
      t_in    = t_in + SUM_W'(w_in[i]);
    end
`ifdef RAND_PICK_NO_REPEAT_EN
    if (last_vld_q && (t_in != SUM_W'(w_in[last_idx_q]))) begin
      t_in             = t_in - SUM_W'(w_in[last_idx_q]);
      w_in[last_idx_q] = '0;
    end
`endif
  end

  assign acc_next = acc_q + SUM_W'(w_q[scan_q]);

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    total_d  = total_q;
    r_d      = r_q;
    acc_d    = acc_q;
    rej_d    = rej_q;
    scan_d   = scan_q;
    index_d  = index_q;
    onehot_d = onehot_q;
    err_d    = err_q;
`ifdef RAND_PICK_NO_REPEAT_EN
    last_vld_d = last_vld_q;
    last_idx_d = last_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          w_d     = w_in;
          total_d = t_in;
          rej_d   = '0;
          if (t_in == '0) begin
            state_d  = RESP;
            err_d    = 1'b1;
            onehot_d = '0;
            index_d  = '0;
          end else begin
            state_d = DRAW;
          end
        end
      end
      DRAW: begin
        if (draw < total_q) begin
          r_d     = draw;
          acc_d   = '0;
          scan_d  = '0;
          state_d = SCAN;
        end else if (rej_q == REJ_W'(MAX_REJECT)) begin
          // draw < 2*T here, so folding back lands inside [0, T)
          r_d     = draw - total_q;
          acc_d   = '0;
          scan_d  = '0;
          state_d = SCAN;
        end else begin
          rej_d = rej_q + REJ_W'(1);
        end
      end
      SCAN: begin
        acc_d = acc_next;
        if (r_q < acc_next) begin
          onehot_d = NUM_CAT'(1) << scan_q;
          index_d  = scan_q;
          err_d    = 1'b0;
          state_d  = RESP;
        end else begin
          scan_d = scan_q + IDX_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
`ifdef RAND_PICK_NO_REPEAT_EN
          if (!err_q) begin
            last_vld_d = 1'b1;
            last_idx_d = index_q;
          end
`endif
          onehot_d = '0;
          index_d  = '0;
          err_d    = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      w_q      <= '{default: '0};
      total_q  <= '0;
      r_q      <= '0;
      acc_q    <= '0;
      rej_q    <= '0;
      scan_q   <= '0;
      index_q  <= '0;
      onehot_q <= '0;
      err_q    <= 1'b0;
`ifdef RAND_PICK_NO_REPEAT_EN
      last_vld_q <= 1'b0;
      last_idx_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      w_q      <= w_d;
      total_q  <= total_d;
      r_q      <= r_d;
      acc_q    <= acc_d;
      rej_q    <= rej_d;
      scan_q   <= scan_d;
      index_q  <= index_d;
      onehot_q <= onehot_d;
      err_q    <= err_d;
`ifdef RAND_PICK_NO_REPEAT_EN
      last_vld_q <= last_vld_d;
      last_idx_q <= last_idx_d;
`endif
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_onehot = onehot_q;
  assign rsp_index  = index_q;
  assign rsp_err    = err_q;

endmodule
